// File: rtl/actuator_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// actuator_pkg : state and command encodings shared by the H-bridge driver
// Revision 1.0
// ---------------------------------------------------------------------------
package actuator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b01;
  localparam logic [1:0] CMD_REV  = 2'b10;

  // 2'b11 is an illegal request and is treated the same as stop.
  function automatic state_t cmd_to_state(input logic [1:0] cmd);
    state_t st;
    case (cmd)
      CMD_FWD: st = FWD;
      CMD_REV: st = REV;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/actuator_hold_driver_hold_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hold_timer : saturating up-counter with sync clear, enable and term match
// Revision 1.0
// ---------------------------------------------------------------------------
module hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             at_term,
  output logic             pre_term
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   count_inc;

  always_comb begin
    count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    count_d   = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != term)) begin
      count_d = count_inc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_term  = (count_q == term);
  // The next enabled increment lands on term.
  assign pre_term = (count_inc == {1'b0, term});

endmodule
`default_nettype wire

// File: rtl/actuator_hold_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// actuator_hold_driver : H-bridge enable driver with minimum hold and dead-time
// Optional fault latch enabled by defining FAULT_LATCH_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module actuator_hold_driver
  import actuator_pkg::*;
#(
  parameter int MIN_HOLD    = 255,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  input  logic       fault,
  output logic       drive_fwd,
  output logic       drive_rev,
  output logic       busy,
  output logic       faulted
);

  localparam int MAX_TERM = (MIN_HOLD > DEAD_CYCLES) ? MIN_HOLD : DEAD_CYCLES;
  localparam int CNT_W    = $clog2(MAX_TERM + 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] DEAD_TERM = CNT_W'(DEAD_CYCLES - 1);

  state_t           state_q, state_d;
  state_t           req_state;
  logic             drive_fwd_q, drive_fwd_d;
  logic             drive_rev_q, drive_rev_d;
  logic             busy_q, busy_d;
  logic             faulted_q, faulted_d;
  logic             timer_clr, timer_en;
  logic [CNT_W-1:0] timer_term;
  logic             at_term, pre_term;

`ifndef FAULT_LATCH_EN
  logic unused_fault;
  assign unused_fault = fault;
`endif

  hold_timer #(
    .WIDTH (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .en       (timer_en),
    .term     (timer_term),
    .at_term  (at_term),
    .pre_term (pre_term)
  );

  always_comb begin
    req_state  = cmd_to_state(cmd);
    state_d    = state_q;
    timer_en   = 1'b0;
    timer_term = HOLD_TERM;

    case (state_q)
      IDLE: state_d = req_state;
      FWD, REV: begin
        timer_en = 1'b1;
        if (at_term && (req_state != state_q)) begin
          state_d = DEAD;
        end
      end
      DEAD: begin
        timer_en   = 1'b1;
        timer_term = DEAD_TERM;
        if (at_term) begin
          state_d = req_state;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FAULT_LATCH_EN
    // Safety outranks the hold time: a fault drops the pins immediately.
    faulted_d = faulted_q | fault;
    if (faulted_d) begin
      state_d = IDLE;
    end
`else
    faulted_d = 1'b0;
`endif

    // One counter serves both phases, so it restarts on every state entry.
    timer_clr = (state_d != state_q) || (state_q == IDLE);

    drive_fwd_d = (state_d == FWD);
    drive_rev_d = (state_d == REV);
    busy_d      = 1'b0;
    if (state_d == DEAD) begin
      busy_d = 1'b1;
    end else if ((state_d == FWD) || (state_d == REV)) begin
      if (state_d != state_q) begin
        busy_d = (HOLD_TERM != '0);
      end else begin
        busy_d = !(at_term || pre_term);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drive_fwd_q <= 1'b0;
      drive_rev_q <= 1'b0;
      busy_q      <= 1'b0;
      faulted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drive_fwd_q <= drive_fwd_d;
      drive_rev_q <= drive_rev_d;
      busy_q      <= busy_d;
      faulted_q   <= faulted_d;
    end
  end

  assign drive_fwd = drive_fwd_q;
  assign drive_rev = drive_rev_q;
  assign busy      = busy_q;
  assign faulted   = faulted_q;

endmodule
`default_nettype wire

// File: tb/tb_actuator_hold_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_actuator_hold_driver : directed table, corner sequences and random run
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_actuator_hold_driver;

  localparam int MIN_HOLD    = 4;
  localparam int DEAD_CYCLES = 2;
`ifdef FAULT_LATCH_EN
  localparam bit FAULT_ON = 1'b1;
`else
  localparam bit FAULT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic       fault = 1'b0;
  logic       drive_fwd, drive_rev, busy, faulted;

  int n_cmp = 0;
  int n_err = 0;

  actuator_hold_driver #(
    .MIN_HOLD    (MIN_HOLD),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .fault     (fault),
    .drive_fwd (drive_fwd),
    .drive_rev (drive_rev),
    .busy      (busy),
    .faulted   (faulted)
  );

  always #5 clk = ~clk;

  // Reference model in terms of pin behaviour: which direction is shown,
  // how many cycles it has been shown, and whether the off time is a dead gap.
  int m_dir = 0;
  bit m_dead = 1'b0;
  bit m_faulted = 1'b0;
  int m_run = 0;

  function automatic int cmd_dir(input logic [1:0] c);
    return (c == 2'b01) ? 1 : ((c == 2'b10) ? 2 : 0);
  endfunction

  task automatic model_step(input logic r, input logic [1:0] c, input logic f);
    int want;
    want = cmd_dir(c);
    if (r) begin
      m_dir = 0; m_dead = 1'b0; m_run = 0; m_faulted = 1'b0;
    end else if (m_faulted || (FAULT_ON && f)) begin
      m_faulted = 1'b1; m_dir = 0; m_dead = 1'b0; m_run = 0;
    end else if (m_dead) begin
      if (m_run >= DEAD_CYCLES) begin
        m_dead = 1'b0; m_dir = want; m_run = 1;
      end else begin
        m_run++;
      end
    end else if (m_dir == 0) begin
      m_dir = want; m_run = 1;
    end else if ((m_run >= MIN_HOLD) && (want != m_dir)) begin
      m_dir = 0; m_dead = 1'b1; m_run = 1;
    end else begin
      m_run++;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".fwd"}, int'(drive_fwd), int'(m_dir == 1));
    check({tag, ".rev"}, int'(drive_rev), int'(m_dir == 2));
    check({tag, ".busy"}, int'(busy),
          int'(m_dead || ((m_dir != 0) && (m_run < MIN_HOLD))));
    check({tag, ".faulted"}, int'(faulted), int'(m_faulted));
    check({tag, ".excl"}, int'(drive_fwd & drive_rev), 0);
  endtask

  task automatic step(input logic r, input logic [1:0] c, input logic f, input string tag);
    @(negedge clk);
    reset = r; cmd = c; fault = f;
    @(posedge clk);
    #1;
    model_step(r, c, f);
    check_model(tag);
  endtask

  typedef struct {
    logic       r;
    logic [1:0] c;
    logic       e_fwd;
    logic       e_rev;
    logic       e_busy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0};

    step(1'b1, 2'b01, 1'b0, "reset");
    check("reset.fwd", int'(drive_fwd), 0);
    check("reset.busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00, 1'b0, $sformatf("idle[%0d]", i));
    end

    // Forward, immediate reverse request, then stop with a mid-dead pulse.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].c, 1'b0, $sformatf("tbl[%0d]", i));
      check($sformatf("tbl[%0d].fwd", i), int'(drive_fwd), int'(tbl[i].e_fwd));
      check($sformatf("tbl[%0d].rev", i), int'(drive_rev), int'(tbl[i].e_rev));
      check($sformatf("tbl[%0d].busy", i), int'(busy), int'(tbl[i].e_busy));
    end

    // Long hold well past any counter wrap point.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 2'b01, 1'b0, "long");
    end
    check("long.fwd_end", int'(drive_fwd), 1);
    check("long.busy_end", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 1'b0, $sformatf("long_stop[%0d]", i));
      check($sformatf("long_stop[%0d].rev", i), int'(drive_rev), 0);
    end
    check("long_stop.fwd", int'(drive_fwd), 0);

    // Reset in the middle of a hold, then reverse without dead-time.
    step(1'b0, 2'b01, 1'b0, "rmid0");
    step(1'b0, 2'b01, 1'b0, "rmid1");
    step(1'b1, 2'b01, 1'b0, "rmid_rst");
    check("rmid_rst.fwd", int'(drive_fwd), 0);
    step(1'b0, 2'b10, 1'b0, "rmid_rev");
    check("rmid_rev.rev", int'(drive_rev), 1);

    // Fault during hold cycle 1.
    step(1'b1, 2'b00, 1'b0, "flt_rst");
    step(1'b0, 2'b01, 1'b0, "flt_fwd");
    step(1'b0, 2'b01, 1'b1, "flt_hit");
`ifdef FAULT_LATCH_EN
    check("flt_hit.fwd", int'(drive_fwd), 0);
    check("flt_hit.faulted", int'(faulted), 1);
    step(1'b0, 2'b10, 1'b0, "flt_ign");
    check("flt_ign.rev", int'(drive_rev), 0);
    check("flt_ign.faulted", int'(faulted), 1);
    step(1'b1, 2'b00, 1'b0, "flt_clr");
    check("flt_clr.faulted", int'(faulted), 0);
`else
    check("flt_hit.fwd", int'(drive_fwd), 1);
    check("flt_hit.faulted", int'(faulted), 0);
    step(1'b1, 2'b00, 1'b0, "flt_clr");
`endif

    // Randomized commands with occasional reset and fault.
    for (int blk = 0; blk < 600; blk++) begin
      logic [1:0] rc;
      int len;
      rc  = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 99) == 0), rc, ($urandom_range(0, 59) == 0),
             $sformatf("rnd[%0d]", blk));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/actuator_hold_driver.md
Name: actuator_hold_driver

Overview:
Output-side counterpart of the input debouncers. It takes a clean motor command from the robot control FSM and drives the H-bridge enable pair. Rules enforced on the pins:
- Each driven direction is held for a minimum time.
- Both outputs are always off for a dead-time between any direction change or stop.
- The two outputs are never asserted together.

Parameters:
MIN_HOLD, 255, minimum consecutive cycles a drive output stays high once asserted (legal range >= 1).
DEAD_CYCLES, 16, exact cycles both outputs stay low after leaving a driven state (legal range >= 1).
CNT_W, $clog2(max(MIN_HOLD,DEAD_CYCLES)+1), internal counter width; derived, not overridden.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cmd  input  2  requested motion: 00 stop, 01 forward, 10 reverse, 11 treated as stop.
fault  input  1  actuator fault. Used only with FAULT_LATCH_EN; ignored otherwise.
drive_fwd  output  1  forward enable, registered.
drive_rev  output  1  reverse enable, registered.
busy  output  1  high in DEAD, and in ACTIVE while the hold time is unexpired.
faulted  output  1  latched fault flag. Constant 0 without FAULT_LATCH_EN.

Behaviour:
- Reset (reset=1 at a posedge):
  - state=IDLE, counter=0.
  - drive_fwd=0, drive_rev=0, busy=0, faulted=0.
  - Reset overrides everything, including mid-hold and mid-dead-time; outputs drop the cycle after the reset edge.
- States: IDLE, FWD, REV, DEAD. All outputs are registered; 1-cycle latency from a sampled cmd to the pins.
- IDLE:
  - cmd=01 goes to FWD; cmd=10 goes to REV; counter cleared.
  - cmd=00 or 11 stays in IDLE.
- FWD/REV:
  - Counter increments each cycle, saturating at MIN_HOLD-1.
  - While counter < MIN_HOLD-1, cmd is ignored and busy=1.
  - Once counter == MIN_HOLD-1: busy=0. If cmd differs from the current direction (including stop/11), go to DEAD with counter cleared.
  - Result: a drive output is high for >= MIN_HOLD cycles.
- DEAD:
  - Both outputs low, busy=1, counter increments.
  - On the edge where counter == DEAD_CYCLES-1, sample cmd: 01 goes to FWD, 10 goes to REV, otherwise IDLE. Counter cleared.
  - cmd during DEAD before that edge is ignored.
  - Both outputs are low for exactly DEAD_CYCLES cycles.
- Invariants: drive_fwd & drive_rev is never 1. A direction reversal never skips DEAD.
- Saturation: the counter never wraps; a hold lasting beyond MIN_HOLD stays at MIN_HOLD-1.
- Simultaneous events:
  - cmd change on the same edge the hold expires: the change is accepted.
  - reset together with any cmd: reset wins.

Optional Feature:
FAULT_LATCH_EN:
- Defined:
  - fault=1 at any posedge (reset=0) forces state DEAD-equivalent outputs: drive_fwd=drive_rev=0, faulted=1 from the next cycle.
  - The state machine is held in IDLE, and cmd is ignored until reset.
  - fault outranks hold time (safety over hold).
- Undefined: the fault input is ignored, faulted is tied 0, and the port list is unchanged.

Decomposition:
- Shared package (actuator_pkg) holds:
  - The state enum (IDLE, FWD, REV, DEAD).
  - The cmd encoding constants (CMD_STOP=2'b00, CMD_FWD=2'b01, CMD_REV=2'b10).
- One natural sub-module: hold_timer, a saturating up-counter with sync clear, enable, and a terminal-match output. It is instantiated once and shared between hold and dead phases via the clear on each state entry.

Test Plan:
(Bench overrides MIN_HOLD=4, DEAD_CYCLES=2.)
1. Reset release, cmd=00 for 10 cycles -> drive_fwd=drive_rev=0, busy=0, faulted=0 throughout.
2. Forward then immediate reverse: cmd=01 at edge e0, then cmd=10 from e1 -> drive_fwd=1 after e0 through e4 (4 cycles), both 0 after e4 for 2 cycles, drive_rev=1 after e6.
3. Stop during dead-time: FWD expires, cmd=00 at expiry, cmd=01 pulse mid-DEAD, cmd=00 at DEAD end -> IDLE, outputs 0; the mid-DEAD pulse has no effect.
4. Long hold: cmd=01 for 300 cycles -> drive_fwd stays 1 and the counter saturates without wrap. cmd=00 then gives 2 dead cycles, then IDLE, with no glitch on drive_rev.
5. Reset mid-hold: reset=1 at hold cycle 2 of FWD -> drive_fwd=0 the next cycle, state IDLE. cmd=10 right after reset release -> drive_rev=1 one cycle later with no dead-time.
6. With FAULT_LATCH_EN: FWD active at hold cycle 1, fault=1 for one cycle -> outputs 0 and faulted=1 the next cycle, cmd=10 ignored; reset clears faulted.
